// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : refill state machine encoding (RUN, REFILL)
//   calc_off_w    : byte-offset width of a cache line (word select + byte bits)
//   calc_idx_w    : cache line index width
//   calc_tag_w    : tag width left over once index and offset are removed
package ifetch_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } fetch_state_t;

    function automatic int calc_off_w(input int words_per_line);
        return $clog2(words_per_line * 4);
    endfunction

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int words_per_line, input int lines);
        return addr_w - calc_idx_w(lines) - calc_off_w(words_per_line);
    endfunction

endpackage

// File: rtl/ins_cache_array.sv
// ins_cache_array
// Direct-mapped instruction cache storage: tag, valid and data arrays.
// Reads are combinational; a whole line is written on the rising edge.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (valid bits only)
//   flush          : clear every valid bit at the next edge
//   rd_idx/rd_tag  : lookup line index and tag
//   rd_word        : word select within the line
//   rd_hit         : line valid and tag matches
//   rd_ins         : selected instruction word of the indexed line
//   wr_en          : write a full line (data, tag, valid)
//   wr_idx/wr_tag  : line being written and its tag
//   wr_line        : refill data, word 0 in the least significant bits
module ins_cache_array
    import ifetch_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int INS_W          = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINES          = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [calc_idx_w(LINES)-1:0]      rd_idx,
    input  logic [calc_tag_w(ADDR_W, WORDS_PER_LINE, LINES)-1:0] rd_tag,
    input  logic [calc_off_w(WORDS_PER_LINE)-3:0] rd_word,
    output logic                              rd_hit,
    output logic [INS_W-1:0]                  rd_ins,
    input  logic                              wr_en,
    input  logic [calc_idx_w(LINES)-1:0]      wr_idx,
    input  logic [calc_tag_w(ADDR_W, WORDS_PER_LINE, LINES)-1:0] wr_tag,
    input  logic [INS_W*WORDS_PER_LINE-1:0]   wr_line
);

    localparam int TAG_W = calc_tag_w(ADDR_W, WORDS_PER_LINE, LINES);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [INS_W-1:0] data_mem [LINES][WORDS_PER_LINE];

    assign rd_hit = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_ins = data_mem[rd_idx][rd_word];

    // Only the valid bits need a reset; stale tag/data behind a cleared
    // valid bit can never produce a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= '0;
            end
            // A line written in the same cycle as a flush survives it:
            // the later assignment to that bit wins.
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                data_mem[wr_idx][w] <= wr_line[w*INS_W +: INS_W];
            end
        end
    end

endmodule

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit
// Instruction-fetch stage: PC register, direct-mapped instruction cache and
// a blocking-miss refill state machine. One registered instruction per cycle
// is produced on cache hits.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   i_stall                  : downstream not ready, hold outputs and PC
//   i_redirect/_pc           : load a new PC and drop the current output
//   i_flush                  : invalidate every cache line
//   o_mem_req/o_mem_addr     : refill request and line-aligned address
//   i_mem_ack/i_mem_data     : refill line return
//   o_valid/o_ins/o_pc       : registered fetch result
//   o_pc_plus4               : o_pc + 4
//   o_hit                    : most recent lookup hit
//
// Refill handshake: o_mem_req is high for every cycle the FSM is in REFILL,
// with o_mem_addr held constant. Memory answers with a single-cycle
// i_mem_ack carrying the whole line on i_mem_data; the line is written on
// that edge and o_mem_req drops the following cycle. i_mem_ack seen while
// no request is outstanding is ignored. A reset drops o_mem_req at once and
// the memory side must forget the request.
module ins_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int              ADDR_W         = 32,
    parameter int              INS_W          = 32,  // must be 32: PC steps by 4
    parameter int              WORDS_PER_LINE = 4,
    parameter int              LINES          = 16,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_stall,
    input  logic                            i_redirect,
    input  logic [ADDR_W-1:0]               i_redirect_pc,
    input  logic                            i_flush,
    output logic                            o_mem_req,
    output logic [ADDR_W-1:0]               o_mem_addr,
    input  logic                            i_mem_ack,
    input  logic [INS_W*WORDS_PER_LINE-1:0] i_mem_data,
    output logic                            o_valid,
    output logic [INS_W-1:0]                o_ins,
    output logic [ADDR_W-1:0]               o_pc,
    output logic [ADDR_W-1:0]               o_pc_plus4,
    output logic                            o_hit
);

    localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
    localparam int IDX_W = calc_idx_w(LINES);
    localparam int TAG_W = calc_tag_w(ADDR_W, WORDS_PER_LINE, LINES);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] miss_addr_q;

    logic              lu_hit;
    logic [INS_W-1:0]  lu_ins;

    logic              issue;       // register a hit to the outputs
    logic              start_miss;  // capture the miss line address
    logic              kill_out;    // force o_valid low
    logic              cache_wr;
    logic              cache_flush;

    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign line_addr   = {pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    // A redirect in the same cycle outranks a flush.
    assign cache_flush = i_flush & ~i_redirect;
    assign o_mem_req   = (state_q == REFILL);
    assign o_mem_addr  = miss_addr_q;

    ins_cache_array #(
        .ADDR_W         (ADDR_W),
        .INS_W          (INS_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINES          (LINES)
    ) u_cache (
        .clk     (clk),
        .rst     (rst),
        .flush   (cache_flush),
        .rd_idx  (pc_q[OFF_W+IDX_W-1:OFF_W]),
        .rd_tag  (pc_q[ADDR_W-1:OFF_W+IDX_W]),
        .rd_word (pc_q[OFF_W-1:2]),
        .rd_hit  (lu_hit),
        .rd_ins  (lu_ins),
        .wr_en   (cache_wr),
        .wr_idx  (miss_addr_q[OFF_W+IDX_W-1:OFF_W]),
        .wr_tag  (miss_addr_q[ADDR_W-1:OFF_W+IDX_W]),
        .wr_line (i_mem_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issue      = 1'b0;
        start_miss = 1'b0;
        kill_out   = 1'b0;
        cache_wr   = 1'b0;
        case (state_q)
            RUN: begin
                if (i_redirect) begin
                    pc_d     = i_redirect_pc;
                    kill_out = 1'b1;
                end else if (i_flush) begin
                    kill_out = 1'b1;
                end else if (i_stall) begin
                    // hold everything, including a pending miss
                end else if (lu_hit) begin
                    issue = 1'b1;
                    pc_d  = pc_plus4;
                end else begin
                    start_miss = 1'b1;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                // Stall does not block the refill; a redirect only moves the
                // PC and lets the outstanding line land in the cache.
                if (i_mem_ack) begin
                    cache_wr = 1'b1;
                    state_d  = RUN;
                end
                if (i_redirect) begin
                    pc_d     = i_redirect_pc;
                    kill_out = 1'b1;
                end else if (i_flush) begin
                    kill_out = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            miss_addr_q <= '0;
            o_valid     <= 1'b0;
            o_hit       <= 1'b0;
            o_ins       <= '0;
            o_pc        <= '0;
            o_pc_plus4  <= ADDR_W'(4);
        end else begin
            pc_q <= pc_d;
            if (kill_out) begin
                o_valid <= 1'b0;
            end else if (issue) begin
                o_valid    <= 1'b1;
                o_hit      <= 1'b1;
                o_ins      <= lu_ins;
                o_pc       <= pc_q;
                o_pc_plus4 <= pc_plus4;
            end else if (start_miss) begin
                o_valid     <= 1'b0;
                o_hit       <= 1'b0;
                miss_addr_q <= line_addr;
            end
        end
    end

endmodule

// File: tb/tb_ins_fetch_unit.sv
module tb_ins_fetch_unit;

    localparam int ADDR_W = 32;
    localparam int INS_W  = 32;
    localparam int WPL    = 4;
    localparam int LINES  = 16;
    localparam int OFF_W  = 4;
    localparam int LINE_W = INS_W * WPL;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_stall = 1'b0;
    logic              i_redirect = 1'b0;
    logic [ADDR_W-1:0] i_redirect_pc = '0;
    logic              i_flush = 1'b0;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack = 1'b0;
    logic [LINE_W-1:0] i_mem_data = '0;
    logic              o_valid;
    logic [INS_W-1:0]  o_ins;
    logic [ADDR_W-1:0] o_pc;
    logic [ADDR_W-1:0] o_pc_plus4;
    logic              o_hit;

    ins_fetch_unit #(
        .ADDR_W(ADDR_W), .INS_W(INS_W), .WORDS_PER_LINE(WPL), .LINES(LINES), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc), .i_flush(i_flush), .o_mem_req(o_mem_req),
        .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
        .o_valid(o_valid), .o_ins(o_ins), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_hit(o_hit)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image: every word is a function of its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < WPL; w++) l[w*INS_W +: INS_W] = mem_word(a + 32'(4 * w));
        return l;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:OFF_W], {OFF_W{1'b0}}};
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> OFF_W) & 32'(LINES - 1));
    endfunction

    // ---------------- memory responder ----------------
    int   ack_delay = 2;
    int   req_age   = 0;
    logic force_ack = 1'b0;   // spurious ack injected by the driver

    initial begin
        forever begin
            @(posedge clk);
            #2;
            i_mem_ack = 1'b0;
            if (force_ack) begin
                i_mem_ack  = 1'b1;
                i_mem_data = {LINE_W{1'b1}};
            end else if (o_mem_req) begin
                if (req_age == ack_delay) begin
                    i_mem_ack  = 1'b1;
                    i_mem_data = mem_line(o_mem_addr);
                    req_age    = 0;
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // ---------------- behavioural model + compare ----------------
    // Cache model: per index, the line address currently held.
    logic [31:0] m_cline [int];
    logic [31:0] m_fpc;      // next address to fetch
    logic [31:0] m_opc;      // address of the instruction on the outputs
    logic [31:0] m_addr;     // outstanding refill line
    logic        m_valid, m_hit, m_refill, m_was_refill;

    function automatic bit m_cached(input logic [31:0] a);
        return m_cline.exists(idx_of(a)) && (m_cline[idx_of(a)] == line_of(a));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_fpc = '0; m_opc = '0; m_addr = '0;
            m_valid = 1'b0; m_hit = 1'b0; m_refill = 1'b0;
            m_cline.delete();
        end else begin
            check("cyc o_valid", 32'(o_valid), 32'(m_valid));
            if (m_valid) begin
                check("cyc o_pc", o_pc, m_opc);
                check("cyc o_ins", o_ins, mem_word(m_opc));
                check("cyc o_pc_plus4", o_pc_plus4, m_opc + 32'd4);
            end
            check("cyc o_hit", 32'(o_hit), 32'(m_hit));
            check("cyc o_mem_req", 32'(o_mem_req), 32'(m_refill));
            if (m_refill) check("cyc o_mem_addr", o_mem_addr, m_addr);

            // inputs present now take effect at the next rising edge
            m_was_refill = m_refill;
            if (!m_refill) begin
                if (i_redirect) begin
                    m_fpc = i_redirect_pc; m_valid = 1'b0;
                end else if (i_flush) begin
                    m_valid = 1'b0;
                end else if (i_stall) begin
                    // outputs held
                end else if (m_cached(m_fpc)) begin
                    m_valid = 1'b1; m_hit = 1'b1; m_opc = m_fpc; m_fpc = m_fpc + 32'd4;
                end else begin
                    m_valid = 1'b0; m_hit = 1'b0; m_refill = 1'b1; m_addr = line_of(m_fpc);
                end
            end else begin
                if (i_mem_ack) m_refill = 1'b0;
                if (i_redirect) begin
                    m_fpc = i_redirect_pc; m_valid = 1'b0;
                end
            end
            if (i_flush && !i_redirect) m_cline.delete();
            if (m_was_refill && i_mem_ack) m_cline[idx_of(m_addr)] = m_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        tick();
        i_redirect    = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        int n = 0;
        while (!o_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, " valid"}, 32'(o_valid), 32'd1);
        check({name, " pc"}, o_pc, pc);
    endtask

    // ---------------- directed sequence ----------------
    int   n;
    logic saw_req;

    initial begin
        repeat (3) tick();
        check("rst o_valid", 32'(o_valid), 32'd0);
        check("rst o_hit", 32'(o_hit), 32'd0);
        check("rst o_mem_req", 32'(o_mem_req), 32'd0);
        check("rst o_ins", o_ins, 32'h0);
        check("rst o_pc", o_pc, 32'h0);
        check("rst o_mem_addr", o_mem_addr, 32'h0);
        check("rst o_pc_plus4", o_pc_plus4, 32'h4);
        rst = 1'b0;

        // cold start: miss at 0, ack in the third request cycle
        tick();
        check("cold req", 32'(o_mem_req), 32'd1);
        check("cold addr", o_mem_addr, 32'h0);
        repeat (3) tick();
        check("replay req low", 32'(o_mem_req), 32'd0);
        check("replay no valid", 32'(o_valid), 32'd0);
        tick();
        check("first valid", 32'(o_valid), 32'd1);
        check("first pc", o_pc, 32'h0);
        check("first ins", o_ins, 32'hC0DE_0000);
        check("first hit", 32'(o_hit), 32'd1);
        tick();
        check("pc 4", o_pc, 32'h4);

        // stall three cycles while 0x4 is on the outputs
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall hold pc", o_pc, 32'h4);
            check("stall hold ins", o_ins, 32'hC0DE_0004);
        end
        i_stall = 1'b0;
        tick();
        check("post stall pc", o_pc, 32'h8);
        check("post stall ins", o_ins, 32'hC0DE_0008);
        tick();
        check("pc c", o_pc, 32'hC);
        tick();
        check("miss 10 valid", 32'(o_valid), 32'd0);
        check("miss 10 req", 32'(o_mem_req), 32'd1);
        check("miss 10 addr", o_mem_addr, 32'h10);

        // redirect to cached 0x0 while refilling 0x10
        redirect(32'h0);
        n = 0;
        while (!o_valid && n < 40) begin
            if (o_mem_req) check("redir refill addr", o_mem_addr, 32'h10);
            tick();
            n++;
        end
        check("redir first valid", 32'(o_valid), 32'd1);
        check("redir first pc", o_pc, 32'h0);
        saw_req = 1'b0;
        n = 0;
        while (o_pc != 32'h10 && n < 20) begin
            tick();
            saw_req = saw_req | o_mem_req;
            n++;
        end
        check("0x10 pc", o_pc, 32'h10);
        check("0x10 hit", 32'(o_hit), 32'd1);
        check("0x10 no refill", 32'(saw_req), 32'd0);

        // flush then refetch 0x0
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush kills valid", 32'(o_valid), 32'd0);
        redirect(32'h0);
        tick();
        check("flush miss req", 32'(o_mem_req), 32'd1);
        check("flush miss hit", 32'(o_hit), 32'd0);
        wait_valid("flush refetch", 32'h0);

        // conflict: 0x100 shares index 0 with 0x000
        redirect(32'h100);
        tick();
        check("conflict req", 32'(o_mem_req), 32'd1);
        check("conflict addr", o_mem_addr, 32'h100);
        wait_valid("conflict fetch", 32'h100);
        redirect(32'h0);
        tick();
        check("evicted req", 32'(o_mem_req), 32'd1);
        check("evicted addr", o_mem_addr, 32'h0);
        wait_valid("evicted refetch", 32'h0);

        // spurious ack while running must change nothing
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();

        // wrap from the top of the address space
        redirect(32'hFFFF_FFFC);
        wait_valid("wrap top", 32'hFFFF_FFFC);
        check("wrap plus4", o_pc_plus4, 32'h0);
        tick();
        check("wrap next valid", 32'(o_valid), 32'd1);
        check("wrap next pc", o_pc, 32'h0);

        // asynchronous reset in the middle of a refill
        redirect(32'h200);
        tick();
        check("pre-rst req", 32'(o_mem_req), 32'd1);
        #3;
        rst = 1'b1;
        #2;
        check("async rst req", 32'(o_mem_req), 32'd0);
        check("async rst valid", 32'(o_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post-rst miss req", 32'(o_mem_req), 32'd1);
        check("post-rst miss addr", o_mem_addr, 32'h0);
        wait_valid("post-rst fetch", 32'h0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
